// File: rtl/i_cache_nway.sv
`default_nettype none
// i_cache_nway: N-way set-associative I-cache with tree PLRU, set/all invalidate, AXI burst refill.
// Optional ICACHE_PERF_EN macro adds hit_cnt/miss_cnt outputs.  Rev 1.0
module i_cache_nway #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAY_NUM      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   no_cache,
  input  logic                   inst_en,
  input  logic [31:0]            pc_next,
  input  logic [31:0]            pcF,
  input  logic                   stallF,
  output logic [31:0]            inst_rdata,
  output logic                   stall,
  input  logic                   inv_en,
  input  logic                   inv_all,
  input  logic [INDEX_WIDTH-1:0] inv_index,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [31:0]            rdata,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  localparam int LINE_NUM  = 1 << INDEX_WIDTH;
  localparam int BW        = OFFSET_WIDTH - 2;
  localparam int BLOCK_NUM = 1 << BW;
  localparam int LOG2_WAY  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int PLRU_BITS = (WAY_NUM > 1) ? WAY_NUM - 1 : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, UNCACHED} state_e;
  state_e state_q, state_d;

  logic [TAG_WIDTH-1:0] tag_mem  [WAY_NUM][LINE_NUM];
  logic [31:0]          data_mem [WAY_NUM][LINE_NUM][BLOCK_NUM];
  logic [WAY_NUM-1:0]   valid_q  [LINE_NUM];
  logic [PLRU_BITS-1:0] plru_q   [LINE_NUM];

  logic [INDEX_WIDTH-1:0] rd_idx_q, pend_idx_q;
  logic [31:0]            araddr_q, saved_q;
  logic [7:0]             arlen_q;
  logic [LOG2_WAY-1:0]    victim_q;
  logic [BW-1:0]          bank_q, cnt_q;
  logic                   arvalid_q, rready_q, first_q, pend_q, pend_all_q;

  logic [INDEX_WIDTH-1:0] w_idx_f, w_rd_idx, w_fill_idx, w_inv_idx;
  logic [TAG_WIDTH-1:0]   w_tag_f, w_fill_tag;
  logic [BW-1:0]          w_bank_f;
  logic [LOG2_WAY-1:0]    w_hit_way, w_victim, w_plru_victim;
  logic                   w_hit_raw, w_hit, w_beat, w_read_finish;
  logic                   w_inv_valid, w_inv_all, w_inv_apply;

  assign w_idx_f    = pcF[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_tag_f    = pcF[31 -: TAG_WIDTH];
  assign w_bank_f   = pcF[OFFSET_WIDTH-1:2];
  assign w_fill_idx = araddr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_fill_tag = araddr_q[31 -: TAG_WIDTH];
  // Right after reset no read address has been captured yet, so look at pcF directly.
  assign w_rd_idx   = first_q ? w_idx_f : rd_idx_q;

  function automatic logic [LOG2_WAY-1:0] plru_walk(input logic [PLRU_BITS-1:0] p);
    logic [LOG2_WAY-1:0] node, way;
    node = '0;
    way  = '0;
    for (int l = 0; l < LOG2_WAY; l++) begin
      way[LOG2_WAY-1-l] = p[node];
      node = (node << 1) + LOG2_WAY'(1) + LOG2_WAY'(p[node]);
    end
    return way;
  endfunction

  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] p,
                                                      input logic [LOG2_WAY-1:0]  way);
    logic [LOG2_WAY-1:0]  node;
    logic [PLRU_BITS-1:0] r;
    logic                 b;
    node = '0;
    r    = p;
    for (int l = 0; l < LOG2_WAY; l++) begin
      b       = way[LOG2_WAY-1-l];
      r[node] = ~b;
      node    = (node << 1) + LOG2_WAY'(1) + LOG2_WAY'(b);
    end
    return r;
  endfunction

  generate
    if (WAY_NUM > 1) begin : g_plru
      assign w_plru_victim = plru_walk(plru_q[w_idx_f]);
    end else begin : g_no_plru
      assign w_plru_victim = '0;
    end
  endgenerate

  always_comb begin
    w_hit_raw = 1'b0;
    w_hit_way = '0;
    w_victim  = w_plru_victim;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (valid_q[w_idx_f][w] && tag_mem[w][w_rd_idx] == w_tag_f) begin
        w_hit_raw = 1'b1;
        w_hit_way = LOG2_WAY'(w);
      end
      if (!valid_q[w_idx_f][w]) w_victim = LOG2_WAY'(w);
    end
  end

  assign w_hit         = inst_en & ~no_cache & w_hit_raw;
  assign w_beat        = rready_q & rvalid;
  assign w_read_finish = w_beat & rlast;

  // Merge an incoming invalidate with one parked during a refill; mixed indices widen to all.
  assign w_inv_valid = pend_q | inv_en;
  assign w_inv_all   = pend_all_q | (inv_en & inv_all) | (pend_q & inv_en & (inv_index != pend_idx_q));
  assign w_inv_idx   = pend_q ? pend_idx_q : inv_index;
  assign w_inv_apply = w_inv_valid & ((state_q != REFILL) | w_read_finish);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!stallF) state_d = LOOKUP;
      LOOKUP: begin
        if (inst_en && no_cache)      state_d = UNCACHED;
        else if (inst_en && !w_hit_raw) state_d = REFILL;
      end
      REFILL:   if (w_read_finish) state_d = IDLE;
      UNCACHED: if (w_read_finish) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      victim_q   <= '0;
      bank_q     <= '0;
      cnt_q      <= '0;
      saved_q    <= '0;
      first_q    <= 1'b1;
      rd_idx_q   <= '0;
      pend_q     <= 1'b0;
      pend_all_q <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= 1'b0;
      rd_idx_q <= stallF ? w_rd_idx : pc_next[OFFSET_WIDTH +: INDEX_WIDTH];
      if (state_q == LOOKUP && state_d != LOOKUP) begin
        arvalid_q <= 1'b1;
        araddr_q  <= no_cache ? pcF : {w_tag_f, w_idx_f, {OFFSET_WIDTH{1'b0}}};
        arlen_q   <= no_cache ? 8'd0 : 8'(BLOCK_NUM - 1);
        victim_q  <= w_victim;
        bank_q    <= w_bank_f;
      end else if (arvalid_q && arready) begin
        arvalid_q <= 1'b0;
      end
      if (arvalid_q && arready) rready_q <= 1'b1;
      else if (w_read_finish)   rready_q <= 1'b0;
      if (w_beat) begin
        cnt_q <= w_read_finish ? '0 : cnt_q + BW'(1);
        if (state_q == UNCACHED || cnt_q == bank_q) saved_q <= rdata;
      end
      if (state_q == REFILL && !w_read_finish) begin
        pend_q     <= w_inv_valid;
        pend_all_q <= w_inv_all;
        pend_idx_q <= w_inv_idx;
      end else begin
        pend_q     <= 1'b0;
        pend_all_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL && w_beat) begin
      data_mem[victim_q][w_fill_idx][cnt_q] <= rdata;
      if (rlast) tag_mem[victim_q][w_fill_idx] <= w_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        valid_q[i] <= '0;
        plru_q[i]  <= '0;
      end
    end else begin
      if (WAY_NUM > 1 && state_q == LOOKUP && w_hit)
        plru_q[w_idx_f] <= plru_touch(plru_q[w_idx_f], w_hit_way);
      if (state_q == REFILL && w_read_finish) begin
        valid_q[w_fill_idx][victim_q] <= 1'b1;
        if (WAY_NUM > 1) plru_q[w_fill_idx] <= plru_touch(plru_q[w_fill_idx], victim_q);
      end
      // Placed after the fill write so an invalidate of the same set wins.
      if (w_inv_apply) begin
        for (int i = 0; i < LINE_NUM; i++)
          if (w_inv_all || w_inv_idx == INDEX_WIDTH'(i)) valid_q[i] <= '0;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == LOOKUP && w_hit && !stallF && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == LOOKUP && state_d == REFILL && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign stall      = rst | ~((state_q == IDLE) | ((state_q == LOOKUP) & (w_hit | ~inst_en)));
  assign inst_rdata = (state_q == LOOKUP) ? data_mem[w_hit_way][w_rd_idx][w_bank_f] : saved_q;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;

  logic w_unused_ok;
  assign w_unused_ok = ^{pcF[1:0], pc_next[31:OFFSET_WIDTH+INDEX_WIDTH], pc_next[OFFSET_WIDTH-1:0]};

endmodule
`default_nettype wire
